// File: rtl/uart_mem_bridge_pkg.sv
// Shared definitions for the UART-to-memory command bridge: FSM encoding, protocol byte
// defaults and packet address width.
package uart_mem_bridge_pkg;

  localparam int unsigned ADDR_W = 16;

  localparam logic [7:0] OP_WRITE_DEF = 8'h57;
  localparam logic [7:0] OP_READ_DEF  = 8'h52;
  localparam logic [7:0] ACK_DEF      = 8'h4B;
  localparam logic [7:0] NAK_DEF      = 8'h45;

  typedef enum logic [3:0] {
    StIdle    = 4'd0,
    StGetAh   = 4'd1,
    StGetAl   = 4'd2,
    StGetData = 4'd3,
    StWrSetup = 4'd4,
    StWrPulse = 4'd5,
    StWrHold  = 4'd6,
    StRdEn    = 4'd7,
    StTxWait  = 4'd8,
    StTxPulse = 4'd9
  } state_t;

  function automatic logic addr_ok(input logic [ADDR_W-1:0] a, input int unsigned depth);
    return {{(32-ADDR_W){1'b0}}, a} < depth;
  endfunction

endpackage

// File: rtl/byte_timeout.sv
// Inter-byte idle counter: raises expired after TIMEOUT_CYCLES enabled cycles without a clear.
module byte_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 5_000_000
) (
  input  logic Clock,
  input  logic Reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] cnt_q;

  // Count saturates at the terminal value so expired stays asserted until cleared.
  assign expired = enable && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable && !expired) begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

endmodule

// File: rtl/uart_mem_bridge.sv
// Parses UART byte packets into single-byte memory reads/writes and returns the read byte
// or an ACK/NAK byte to the UART transmitter.
module uart_mem_bridge
  import uart_mem_bridge_pkg::*;
#(
  parameter int unsigned MEM_DEPTH      = 501,
  parameter int unsigned READ_LAT       = 2,
  parameter int unsigned TIMEOUT_CYCLES = 5_000_000,
  parameter logic [7:0]  OP_WRITE       = OP_WRITE_DEF,
  parameter logic [7:0]  OP_READ        = OP_READ_DEF,
  parameter logic [7:0]  ACK_BYTE       = ACK_DEF,
  parameter logic [7:0]  NAK_BYTE       = NAK_DEF
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_busy,
  output logic [31:0] Address,
  output logic        MemWrite,
  output logic        ler,
  output logic [7:0]  WriteData,
  input  logic [7:0]  ReadData,
  output logic        busy,
  output logic        overrun
);

  localparam int unsigned LatW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

  state_t            state_q;
  logic              is_wr_q;
  logic [7:0]        ah_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LatW-1:0]   rd_cnt_q;
  logic [ADDR_W-1:0] pkt_addr;
  logic              to_en;
  logic              to_clr;
  logic              to_exp;
  logic              drop;

  assign pkt_addr = {ah_q, rx_data};
  assign to_en    = state_q inside {StGetAh, StGetAl, StGetData};
  assign to_clr   = rx_valid || !to_en;
  assign drop     = rx_valid && (state_q inside {StWrSetup, StWrPulse, StWrHold, StRdEn,
                                                 StTxWait, StTxPulse});

  byte_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_byte_timeout (
    .Clock  (Clock),
    .Reset  (Reset),
    .clear  (to_clr),
    .enable (to_en),
    .expired(to_exp)
  );

  // Every output is registered and updated together with the state it belongs to.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q   <= StIdle;
      is_wr_q   <= 1'b0;
      ah_q      <= '0;
      addr_q    <= '0;
      rd_cnt_q  <= '0;
      tx_data   <= '0;
      tx_start  <= 1'b0;
      Address   <= '0;
      MemWrite  <= 1'b0;
      ler       <= 1'b0;
      WriteData <= '0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      overrun <= drop;
      unique case (state_q)
        StIdle: begin
          if (rx_valid && (rx_data == OP_WRITE || rx_data == OP_READ)) begin
            is_wr_q <= (rx_data == OP_WRITE);
            busy    <= 1'b1;
            state_q <= StGetAh;
          end
        end
        StGetAh: begin
          if (rx_valid) begin
            ah_q    <= rx_data;
            state_q <= StGetAl;
          end else if (to_exp) begin
            busy    <= 1'b0;
            state_q <= StIdle;
          end
        end
        StGetAl: begin
          if (rx_valid) begin
            addr_q <= pkt_addr;
            if (is_wr_q) begin
              state_q <= StGetData;
            end else if (addr_ok(pkt_addr, MEM_DEPTH)) begin
              Address  <= {{(32-ADDR_W){1'b0}}, pkt_addr};
              ler      <= 1'b1;
              rd_cnt_q <= '0;
              state_q  <= StRdEn;
            end else begin
              tx_data <= NAK_BYTE;
              state_q <= StTxWait;
            end
          end else if (to_exp) begin
            busy    <= 1'b0;
            state_q <= StIdle;
          end
        end
        StGetData: begin
          if (rx_valid) begin
            if (addr_ok(addr_q, MEM_DEPTH)) begin
              Address   <= {{(32-ADDR_W){1'b0}}, addr_q};
              WriteData <= rx_data;
              state_q   <= StWrSetup;
            end else begin
              tx_data <= NAK_BYTE;
              state_q <= StTxWait;
            end
          end else if (to_exp) begin
            busy    <= 1'b0;
            state_q <= StIdle;
          end
        end
        StWrSetup: begin
          MemWrite <= 1'b1;
          state_q  <= StWrPulse;
        end
        StWrPulse: begin
          MemWrite <= 1'b0;
          state_q  <= StWrHold;
        end
        StWrHold: begin
          tx_data <= ACK_BYTE;
          state_q <= StTxWait;
        end
        StRdEn: begin
          if (rd_cnt_q == LatW'(READ_LAT - 1)) begin
            ler     <= 1'b0;
            tx_data <= ReadData;
            state_q <= StTxWait;
          end else begin
            rd_cnt_q <= rd_cnt_q + LatW'(1);
          end
        end
        StTxWait: begin
          if (!tx_busy) begin
            tx_start <= 1'b1;
            state_q  <= StTxPulse;
          end
        end
        StTxPulse: begin
          tx_start <= 1'b0;
          busy     <= 1'b0;
          state_q  <= StIdle;
        end
        default: begin
          MemWrite <= 1'b0;
          ler      <= 1'b0;
          tx_start <= 1'b0;
          busy     <= 1'b0;
          state_q  <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_mem_bridge.sv
// Directed bench for uart_mem_bridge with a behavioural 501x8 byte memory.
module tb_uart_mem_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;
  logic [31:0] Address;
  logic        MemWrite;
  logic        ler;
  logic [7:0]  WriteData;
  logic [7:0]  ReadData;
  logic        busy;
  logic        overrun;

  uart_mem_bridge #(
    .MEM_DEPTH     (501),
    .READ_LAT      (2),
    .TIMEOUT_CYCLES(50)
  ) dut (
    .Clock    (clk),
    .Reset    (rst),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .tx_busy  (tx_busy),
    .Address  (Address),
    .MemWrite (MemWrite),
    .ler      (ler),
    .WriteData(WriteData),
    .ReadData (ReadData),
    .busy     (busy),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:500];

  always @(posedge clk) begin
    if (MemWrite && Address < 501) mem[Address[8:0]] <= WriteData;
  end

  always_comb begin
    ReadData = 8'h00;
    if (ler && Address < 501) ReadData = mem[Address[8:0]];
  end

  int          cyc = 0;
  int          wr_cycles = 0;
  int          ler_cycles = 0;
  int          tx_cnt = 0;
  int          ovr_cnt = 0;
  int          last_rx_cyc = 0;
  int          tx_cyc = 0;
  logic        both_high = 1'b0;
  logic        ler_prev = 1'b0;
  logic        ler_addr_bad = 1'b0;
  logic [31:0] wr_addr = '0;
  logic [7:0]  wr_data = '0;
  logic [31:0] ler_addr = '0;
  logic [7:0]  tx_last = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    ler_prev <= ler;
    if (MemWrite) begin
      wr_cycles <= wr_cycles + 1;
      wr_addr   <= Address;
      wr_data   <= WriteData;
    end
    if (ler) begin
      ler_cycles <= ler_cycles + 1;
      if (ler_prev && Address != ler_addr) ler_addr_bad <= 1'b1;
      ler_addr <= Address;
    end
    if (MemWrite && ler) both_high <= 1'b1;
    if (tx_start) begin
      tx_cnt  <= tx_cnt + 1;
      tx_last <= tx_data;
      tx_cyc  <= cyc;
    end
    if (overrun) ovr_cnt <= ovr_cnt + 1;
    if (rx_valid) last_rx_cyc <= cyc;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #2;
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #2;
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  int wr0, ler0, tx0, ovr0;

  initial begin
    for (int i = 0; i < 501; i++) mem[i] = 8'h00;
    rst      = 1'b1;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    tx_busy  = 1'b0;
    idle(3);
    rst = 1'b0;
    idle(1);
    check("rst_memwrite", {31'd0, MemWrite}, 32'd0);
    check("rst_ler", {31'd0, ler}, 32'd0);
    check("rst_tx_start", {31'd0, tx_start}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_address", Address, 32'd0);
    check("rst_tx_data", {24'd0, tx_data}, 32'd0);

    // 1: write 0x06 to address 50
    wr0 = wr_cycles; tx0 = tx_cnt;
    send_byte(8'h57); send_byte(8'h00); send_byte(8'h32); send_byte(8'h06);
    idle(20);
    check("t1_wr_cycles", wr_cycles - wr0, 1);
    check("t1_wr_addr", wr_addr, 32'd50);
    check("t1_wr_data", {24'd0, wr_data}, 32'h06);
    check("t1_mem50", {24'd0, mem[50]}, 32'h06);
    check("t1_tx_cnt", tx_cnt - tx0, 1);
    check("t1_tx_data", {24'd0, tx_last}, 32'h4B);
    check("t1_latency", tx_cyc - last_rx_cyc, 5);
    check("t1_busy", {31'd0, busy}, 32'd0);

    // 2: read back address 50
    ler0 = ler_cycles; tx0 = tx_cnt;
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h32);
    idle(20);
    check("t2_ler_cycles", ler_cycles - ler0, 2);
    check("t2_ler_addr", ler_addr, 32'd50);
    check("t2_ler_addr_stable", {31'd0, ler_addr_bad}, 32'd0);
    check("t2_tx_cnt", tx_cnt - tx0, 1);
    check("t2_tx_data", {24'd0, tx_last}, 32'h06);
    check("t2_addr_idle", Address, 32'd50);

    // 3: out-of-range write (address 501)
    wr0 = wr_cycles; ler0 = ler_cycles; tx0 = tx_cnt;
    send_byte(8'h57); send_byte(8'h01); send_byte(8'hF5); send_byte(8'hAA);
    idle(20);
    check("t3_no_write", wr_cycles - wr0, 0);
    check("t3_no_read", ler_cycles - ler0, 0);
    check("t3_tx_data", {24'd0, tx_last}, 32'h45);
    check("t3_tx_cnt", tx_cnt - tx0, 1);
    check("t3_latency", tx_cyc - last_rx_cyc, 2);
    check("t3_mem50", {24'd0, mem[50]}, 32'h06);

    // 4: partial packet times out, next read works
    tx0 = tx_cnt;
    send_byte(8'h57); send_byte(8'h00);
    idle(51);
    check("t4_timeout_idle", {31'd0, busy}, 32'd0);
    check("t4_no_tx", tx_cnt - tx0, 0);
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h32);
    idle(20);
    check("t4_tx_cnt", tx_cnt - tx0, 1);
    check("t4_tx_data", {24'd0, tx_last}, 32'h06);

    // 5: response held off by tx_busy, extra bytes dropped
    tx0 = tx_cnt; ovr0 = ovr_cnt;
    tx_busy = 1'b1;
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h32);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    idle(80);
    check("t5_no_tx_while_busy", tx_cnt - tx0, 0);
    check("t5_overrun", ovr_cnt - ovr0, 3);
    check("t5_busy_high", {31'd0, busy}, 32'd1);
    tx_busy = 1'b0;
    idle(10);
    check("t5_tx_cnt", tx_cnt - tx0, 1);
    check("t5_tx_data", {24'd0, tx_last}, 32'h06);

    // 6: reset while MemWrite is high
    send_byte(8'h57); send_byte(8'h00); send_byte(8'h10); send_byte(8'h77);
    idle(1);
    check("t6_in_wr_pulse", {31'd0, MemWrite}, 32'd1);
    rst = 1'b1;
    #1;
    check("t6_rst_memwrite", {31'd0, MemWrite}, 32'd0);
    check("t6_rst_ler", {31'd0, ler}, 32'd0);
    check("t6_rst_tx_start", {31'd0, tx_start}, 32'd0);
    check("t6_rst_busy", {31'd0, busy}, 32'd0);
    idle(2);
    rst = 1'b0;
    idle(1);
    check("t6_mem16_untouched", {24'd0, mem[16]}, 32'h00);
    tx0 = tx_cnt;
    send_byte(8'h57); send_byte(8'h00); send_byte(8'h10); send_byte(8'h77);
    idle(20);
    check("t6_mem16", {24'd0, mem[16]}, 32'h77);
    check("t6_tx_data", {24'd0, tx_last}, 32'h4B);
    check("t6_tx_cnt", tx_cnt - tx0, 1);

    // 7: unknown opcode ignored
    ovr0 = ovr_cnt; tx0 = tx_cnt;
    send_byte(8'h41);
    idle(5);
    check("t7_no_overrun", ovr_cnt - ovr0, 0);
    check("t7_idle", {31'd0, busy}, 32'd0);
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h10);
    idle(20);
    check("t7_tx_cnt", tx_cnt - tx0, 1);
    check("t7_tx_data", {24'd0, tx_last}, 32'h77);
    check("never_both_enables", {31'd0, both_high}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
